// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Memory initiator for a single-port synchronous RAM with a registered read
//   (one cycle of latency). The CPU side issues single-byte writes or read
//   bursts over a valid/ready request channel. Read bursts are pipelined at
//   one byte per cycle and the bytes are returned packed on a valid/ready
//   response channel.
//
// Ports
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 asynchronous active-low reset
//   req_valid  in   1                 request present
//   req_ready  out  1                 high only while idle
//   req_we     in   1                 1 = single-byte write, 0 = read burst
//   req_addr   in   ADDR_W            start address
//   req_len    in   3                 read length (0 -> 1, clamped to MAX_BURST)
//   req_wdata  in   DATA_W            write byte
//   rsp_valid  out  1                 response present
//   rsp_ready  in   1                 consumer accepts the response
//   rsp_data   out  MAX_BURST*DATA_W  read bytes, byte k at [8k+7:8k]; 0 for writes
//   ram_addr   out  ADDR_W            RAM address (registered)
//   ram_data   out  DATA_W            RAM write data (registered)
//   ram_we     out  1                 RAM write enable (registered)
//   ram_q      in   DATA_W            RAM read data
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [2:0]                  req_len,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [MAX_BURST*DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_data,
  output logic                        ram_we,
  input  logic [DATA_W-1:0]           ram_q
);

  localparam int RSP_W = MAX_BURST * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Length 0 means one byte; anything above MAX_BURST is clamped.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    logic [2:0] res;
    if (len == 3'd0) begin
      res = 3'd1;
    end else if (int'(len) > MAX_BURST) begin
      res = 3'(MAX_BURST);
    end else begin
      res = len;
    end
    return res;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [ADDR_W-1:0]   w_ram_addr_nxt;
  logic [DATA_W-1:0]   r_ram_data;
  logic [DATA_W-1:0]   w_ram_data_nxt;
  logic                r_ram_we;
  logic                w_ram_we_nxt;
  logic                r_rsp_valid;
  logic                w_rsp_valid_nxt;
  logic [RSP_W-1:0]    r_rsp_data;
  logic [RSP_W-1:0]    w_rsp_data_nxt;
  // Burst assembly buffer, kept apart from rsp_data so the previous response
  // stays visible until the new burst completes.
  logic [RSP_W-1:0]    r_buf;
  logic [RSP_W-1:0]    w_buf_nxt;
  logic [2:0]          r_len;
  logic [2:0]          w_len_nxt;
  // Index of the upcoming clock edge relative to the accept edge E0.
  logic [3:0]          r_edge;
  logic [3:0]          w_edge_nxt;

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign ram_we    = r_ram_we;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_data_nxt  = r_ram_data;
    w_ram_we_nxt    = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_buf_nxt       = r_buf;
    w_len_nxt       = r_len;
    w_edge_nxt      = r_edge;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_ram_addr_nxt = req_addr;
          if (req_we) begin
            w_ram_data_nxt = req_wdata;
            w_ram_we_nxt   = 1'b1;
            w_state_nxt    = ST_WRITE;
          end else begin
            w_len_nxt   = clamp_len(req_len);
            w_edge_nxt  = 4'd1;
            w_buf_nxt   = {RSP_W{1'b0}};
            w_state_nxt = ST_READ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // RAM commits the byte on this edge; we drops back via the default.
        w_rsp_data_nxt  = {RSP_W{1'b0}};
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = ST_RESP;
      end

      ST_READ: begin
        // At edge j the RAM samples addr+j-1; present addr+j while beats remain.
        if ({1'b0, r_len} > r_edge) begin
          w_ram_addr_nxt = r_ram_addr + ADDR_W'(1);
        end else begin
          w_ram_addr_nxt = r_ram_addr;
        end
        // ram_q at edge j holds the byte sampled at edge j-1, i.e. byte j-2.
        for (int b = 0; b < MAX_BURST; b++) begin
          if (r_edge == 4'(b + 2)) begin
            w_buf_nxt[b*DATA_W +: DATA_W] = ram_q;
          end else begin
            w_buf_nxt[b*DATA_W +: DATA_W] = r_buf[b*DATA_W +: DATA_W];
          end
        end
        if (r_edge == ({1'b0, r_len} + 4'd1)) begin
          w_rsp_data_nxt  = w_buf_nxt;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_state_nxt = ST_READ;
        end
        w_edge_nxt = r_edge + 4'd1;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_addr  <= {ADDR_W{1'b0}};
      r_ram_data  <= {DATA_W{1'b0}};
      r_ram_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {RSP_W{1'b0}};
      r_buf       <= {RSP_W{1'b0}};
      r_len       <= 3'd0;
      r_edge      <= 4'd0;
    end else begin
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_data  <= w_ram_data_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_buf       <= w_buf_nxt;
      r_len       <= w_len_nxt;
      r_edge      <= w_edge_nxt;
    end
  end

endmodule
